// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one data RAM port between the CPU and the loader.
// Master 0 has priority; master 1 is guaranteed a grant after a bounded wait.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0] RL = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                state_q;
  logic                  we_q;
  logic [2:0]            wait_q;
  logic [SW-1:0]         starve_q;
  logic [SW-1:0]         starve_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  ram_wren_q;
  logic                  gid_q;
  logic                  m0_ack_q;
  logic                  m1_ack_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q;
  logic [DATA_WIDTH-1:0] m1_rdata_q;

  logic                  any_req;
  logic                  pick_m1;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Winner selection and starvation counter update for an IDLE cycle
  always_comb begin
    any_req   = m0_req | m1_req;
    pick_m1   = m1_req & (~m0_req | (starve_q == S_MAX));
    win_we    = pick_m1 ? m1_we    : m0_we;
    win_addr  = pick_m1 ? m1_addr  : m0_addr;
    win_wdata = pick_m1 ? m1_wdata : m0_wdata;
    starve_d  = starve_q;
    if (pick_m1 || !m1_req) begin
      starve_d = '0;
    end else if (starve_q != S_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Transaction FSM with registered RAM-side and master-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      wait_q      <= '0;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wren_q  <= 1'b0;
      gid_q       <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ram_wren_q <= 1'b0;
          starve_q   <= starve_d;
          if (any_req) begin
            ram_addr_q  <= win_addr;
            ram_wdata_q <= win_wdata;
            we_q        <= win_we;
            ram_wren_q  <= win_we;
            gid_q       <= pick_m1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_wren_q <= 1'b0;
          if (we_q) begin
            m0_ack_q <= ~gid_q;
            m1_ack_q <= gid_q;
            state_q  <= S_ACK;
          end else begin
            wait_q  <= RL;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q == 3'd1) begin
            if (gid_q) begin
              m1_rdata_q <= ram_rdata;
            end else begin
              m0_rdata_q <= ram_rdata;
            end
            m0_ack_q <= ~gid_q;
            m1_ack_q <= gid_q;
            state_q  <= S_ACK;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wren  = ram_wren_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus on two arbiter instances
// (read latency 1 and 3) checked every cycle against a transaction model.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m_req   [2][2];
  logic        m_we    [2][2];
  logic [14:0] m_addr  [2][2];
  logic [31:0] m_wdata [2][2];
  logic        m_ack   [2][2];
  logic [31:0] m_rdata [2][2];
  logic [14:0] ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic        ram_wren  [2];
  logic [31:0] ram_rdata [2];
  logic        busy      [2];
  logic        gid       [2];

  ram_port_arbiter #(.READ_LATENCY(1)) u0 (
    .clk(clk), .reset(reset),
    .m0_req(m_req[0][0]), .m0_we(m_we[0][0]),
    .m0_addr(m_addr[0][0]), .m0_wdata(m_wdata[0][0]),
    .m0_ack(m_ack[0][0]), .m0_rdata(m_rdata[0][0]),
    .m1_req(m_req[0][1]), .m1_we(m_we[0][1]),
    .m1_addr(m_addr[0][1]), .m1_wdata(m_wdata[0][1]),
    .m1_ack(m_ack[0][1]), .m1_rdata(m_rdata[0][1]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_wren(ram_wren[0]), .ram_rdata(ram_rdata[0]),
    .busy(busy[0]), .grant_id(gid[0])
  );

  ram_port_arbiter #(.READ_LATENCY(3)) u1 (
    .clk(clk), .reset(reset),
    .m0_req(m_req[1][0]), .m0_we(m_we[1][0]),
    .m0_addr(m_addr[1][0]), .m0_wdata(m_wdata[1][0]),
    .m0_ack(m_ack[1][0]), .m0_rdata(m_rdata[1][0]),
    .m1_req(m_req[1][1]), .m1_we(m_we[1][1]),
    .m1_addr(m_addr[1][1]), .m1_wdata(m_wdata[1][1]),
    .m1_ack(m_ack[1][1]), .m1_rdata(m_rdata[1][1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_wren(ram_wren[1]), .ram_rdata(ram_rdata[1]),
    .busy(busy[1]), .grant_id(gid[1])
  );

  // Synchronous RAMs with 1 and 3 edges of read latency
  logic [31:0] mem0 [0:32767];
  logic [31:0] mem1 [0:32767];
  logic [31:0] p0;
  logic [31:0] p1 [1:3];

  always @(posedge clk) begin
    if (ram_wren[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    p0 <= mem0[ram_addr[0]];
  end

  always @(posedge clk) begin
    if (ram_wren[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    p1[1] <= mem1[ram_addr[1]];
    p1[2] <= p1[1];
    p1[3] <= p1[2];
  end

  assign ram_rdata[0] = p0;
  assign ram_rdata[1] = p1[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, a, e, cyc);
    end
  endtask

  // Transaction-level model: a granted transaction occupies a
  // fixed span of cycles measured from its grant cycle t0.
  bit          mv   [2];
  bit          act  [2];
  int          t0   [2];
  int          len  [2];
  bit          mw   [2];
  bit          mwe  [2];
  logic [14:0] ma   [2];
  logic [31:0] mwd  [2];
  logic [14:0] la   [2];
  logic [31:0] lwd  [2];
  bit          lg   [2];
  logic [31:0] lrd  [2][2];
  int          stv  [2];
  logic [31:0] emem [2][0:32767];

  int k;
  bit e_wren, e_ack0, e_ack1, w;
  int dut_stv;

  int log_m [$];
  int log_c [$];
  int wren_cnt0 = 0;
  bit smon = 1'b0;
  int starve_nz = 0;

  function automatic int rl(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_reset(input int i);
    act[i]    = 1'b0;
    la[i]     = '0;
    lwd[i]    = '0;
    lg[i]     = 1'b0;
    lrd[i][0] = '0;
    lrd[i][1] = '0;
    stv[i]    = 0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!mv[i]) begin
        if (reset) begin
          model_reset(i);
          mv[i] = 1'b1;
        end
      end else begin
        if (act[i] && (cyc - t0[i]) >= len[i]) act[i] = 1'b0;
        k      = cyc - t0[i];
        e_wren = act[i] && k == 1 && mwe[i];
        e_ack0 = act[i] && k == len[i] - 1 && !mw[i];
        e_ack1 = act[i] && k == len[i] - 1 && mw[i];
        if (act[i] && k == len[i] - 1 && !mwe[i])
          lrd[i][mw[i]] = emem[i][ma[i]];
        dut_stv = (i == 0) ? int'(u0.starve_q) : int'(u1.starve_q);
        chk($sformatf("u%0d.busy", i), 64'(busy[i]), 64'(act[i]));
        chk($sformatf("u%0d.wren", i), 64'(ram_wren[i]), 64'(e_wren));
        chk($sformatf("u%0d.addr", i), 64'(ram_addr[i]), 64'(la[i]));
        chk($sformatf("u%0d.wdata", i), 64'(ram_wdata[i]), 64'(lwd[i]));
        chk($sformatf("u%0d.gid", i), 64'(gid[i]), 64'(lg[i]));
        chk($sformatf("u%0d.ack0", i), 64'(m_ack[i][0]), 64'(e_ack0));
        chk($sformatf("u%0d.ack1", i), 64'(m_ack[i][1]), 64'(e_ack1));
        chk($sformatf("u%0d.rd0", i), 64'(m_rdata[i][0]), 64'(lrd[i][0]));
        chk($sformatf("u%0d.rd1", i), 64'(m_rdata[i][1]), 64'(lrd[i][1]));
        chk($sformatf("u%0d.starve", i), 64'(dut_stv), 64'(stv[i]));
        if (e_wren) emem[i][ma[i]] = mwd[i];
        if (reset) begin
          model_reset(i);
        end else if (!act[i]) begin
          if (m_req[i][0] || m_req[i][1]) begin
            w = m_req[i][1] && (!m_req[i][0] || stv[i] == 4);
            if (w || !m_req[i][1]) stv[i] = 0;
            else if (stv[i] < 4) stv[i] = stv[i] + 1;
            act[i] = 1'b1;
            t0[i]  = cyc;
            mw[i]  = w;
            mwe[i] = m_we[i][w];
            ma[i]  = m_addr[i][w];
            mwd[i] = m_wdata[i][w];
            len[i] = mwe[i] ? 3 : 3 + rl(i);
            la[i]  = ma[i];
            lwd[i] = mwd[i];
            lg[i]  = w;
          end else begin
            stv[i] = 0;
          end
        end
      end
    end
    if (mv[0]) begin
      if (m_ack[0][0]) begin log_m.push_back(0); log_c.push_back(cyc); end
      if (m_ack[0][1]) begin log_m.push_back(1); log_c.push_back(cyc); end
      if (ram_wren[0]) wren_cnt0++;
      if (smon && u0.starve_q != 0) starve_nz++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One master transaction; lat counts cycles from req raise to ack.
  task automatic txn(input int i, input int m, input bit we,
                     input logic [14:0] a, input logic [31:0] d,
                     input bit keep, output int lat,
                     output logic [31:0] rd);
    m_req[i][m]   = 1'b1;
    m_we[i][m]    = we;
    m_addr[i][m]  = a;
    m_wdata[i][m] = d;
    lat = -1;
    rd  = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (m_ack[i][m]) begin
        lat = n;
        rd  = m_rdata[i][m];
        break;
      end
    end
    if (lat < 0) begin
      nchk++;
      nerr++;
      $display("FAIL ack_timeout u%0d m%0d: no ack within 60 cycles", i, m);
    end
    step();
    if (!keep) m_req[i][m] = 1'b0;
  endtask

  int          lat, lat_a, lat_b, base;
  logic [31:0] rd, rd_a, rd_b;
  int          exp4 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int m = 0; m < 2; m++) begin
        m_req[i][m]   = 1'b0;
        m_we[i][m]    = 1'b0;
        m_addr[i][m]  = '0;
        m_wdata[i][m] = '0;
      end
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_addr", 64'(ram_addr[0]), 64'd0);
    chk("rst_wren", 64'(ram_wren[0]), 64'd0);
    chk("rst_gid", 64'(gid[0]), 64'd0);
    chk("rst_rd0", 64'(m_rdata[0][0]), 64'd0);
    step();

    txn(0, 0, 1'b1, 15'h010, 32'hDEADBEEF, 1'b0, lat, rd);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_wren_cycles", 64'(wren_cnt0), 64'd1);

    txn(0, 0, 1'b0, 15'h010, 32'h0, 1'b0, lat, rd);
    chk("t2_lat", 64'(lat), 64'd3);
    chk("t2_rdata", 64'(rd), 64'hDEADBEEF);
    chk("t2_wren_cycles", 64'(wren_cnt0), 64'd1);

    txn(1, 1, 1'b1, 15'h020, 32'h12345678, 1'b0, lat, rd);
    chk("t3_wlat", 64'(lat), 64'd2);
    txn(1, 1, 1'b0, 15'h020, 32'h0, 1'b0, lat, rd);
    chk("t3_lat", 64'(lat), 64'd5);
    chk("t3_rdata", 64'(rd), 64'h12345678);
    chk("t3_gid", 64'(gid[1]), 64'd1);

    base = log_m.size();
    fork
      begin
        for (int n = 0; n < 8; n++)
          txn(0, 0, 1'b1, 15'(32'h100 + n), 32'(n), n < 7, lat_a, rd_a);
      end
      begin
        for (int n = 0; n < 2; n++)
          txn(0, 1, 1'b1, 15'(32'h200 + n), 32'(n + 8), n < 1, lat_b, rd_b);
      end
    join
    chk("t4_count", 64'(log_m.size() - base), 64'd10);
    if (log_m.size() >= base + 10) begin
      for (int j = 0; j < 10; j++)
        chk($sformatf("t4_grant%0d", j), 64'(log_m[base + j]), 64'(exp4[j]));
      for (int j = 1; j < 10; j++)
        chk($sformatf("t4_gap%0d", j),
            64'(log_c[base + j] - log_c[base + j - 1]), 64'd3);
    end

    m_req[0][0]  = 1'b1;
    m_we[0][0]   = 1'b0;
    m_addr[0][0] = 15'h010;
    step();
    step();
    reset = 1'b1;
    m_req[0][0] = 1'b0;
    @(negedge clk);
    chk("t5_in_wait", 64'(busy[0]), 64'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy[0]), 64'd0);
    chk("t5_ack0", 64'(m_ack[0][0]), 64'd0);
    chk("t5_ack1", 64'(m_ack[0][1]), 64'd0);
    chk("t5_wren", 64'(ram_wren[0]), 64'd0);
    step();
    txn(0, 1, 1'b1, 15'h030, 32'hCAFEF00D, 1'b0, lat, rd);
    chk("t5_wlat", 64'(lat), 64'd2);

    smon = 1'b1;
    base = log_m.size();
    for (int n = 0; n < 6; n++)
      txn(0, 0, 1'b1, 15'(32'h300 + n), 32'(n * 3), n < 5, lat, rd);
    smon = 1'b0;
    chk("t6_count", 64'(log_m.size() - base), 64'd6);
    if (log_m.size() >= base + 6) begin
      for (int j = 0; j < 6; j++)
        chk($sformatf("t6_grant%0d", j), 64'(log_m[base + j]), 64'd0);
    end
    chk("t6_starve_nz", 64'(starve_nz), 64'd0);

    txn(0, 0, 1'b0, 15'h030, 32'h0, 1'b0, lat, rd);
    chk("t7_lat", 64'(lat), 64'd3);
    chk("t7_rdata", 64'(rd), 64'hCAFEF00D);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
